// File: rtl/fpu_pkg.sv
// Shared floating-point helpers for the min/max reduction datapath.
// Latency: none (constants, types and a combinational helper only).
// Backpressure: not applicable.
//
// Contents:
//   FP_QNAN    canonical quiet NaN reported for frames with no ordered element
//   state_t    reduction FSM states (IDLE / ACC / DONE)
//   fp_is_nan  true for any NaN encoding (exponent all ones, mantissa nonzero)
package fpu_pkg;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no ordered element held yet
        ST_ACC  = 2'd1,   // max/min hold at least one ordered element
        ST_DONE = 2'd2    // result record presented, input stalled
    } state_t;

    function automatic logic fp_is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/FloatingCompare.sv
// Combinational IEEE-754 single-precision ordering test: ge = (a >= b).
// Latency: zero cycles, purely combinational.
// Backpressure: not applicable.
//
// Ports:
//   a, b  in  32  operands (callers keep NaNs away; their result is arbitrary)
//   ge    out 1   a ranks at or above b
//
// Sign is treated as a real ordering bit, so +0 ranks above -0. With equal
// signs the magnitude field (exponent:mantissa) orders like an unsigned
// integer, inverted for negative operands. Infinities fall out naturally.
module FloatingCompare (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ge
);

    logic        sign_a;
    logic        sign_b;
    logic [30:0] mag_a;
    logic [30:0] mag_b;

    assign sign_a = a[31];
    assign sign_b = b[31];
    assign mag_a  = a[30:0];
    assign mag_b  = b[30:0];

    always_comb begin
        ge = 1'b0;
        if (sign_a != sign_b) begin
            // Different signs: the positive operand is the larger one.
            ge = ~sign_a;
        end else if (!sign_a) begin
            ge = (mag_a >= mag_b);
        end else begin
            // Both negative: larger magnitude means smaller value.
            ge = (mag_a <= mag_b);
        end
    end

endmodule

// File: rtl/float_minmax_reduce.sv
// Streaming frame reduction: max, min, their positions, element count, NaN/empty/saturation flags.
// Latency: result record valid the cycle after the last-beat handshake; one element per cycle.
// Backpressure: while a result is held (out_valid && !out_ready) in_ready stays low.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last input element stream, in_last closes a frame
//   out_valid/out_ready               result record handshake
//   out_max, out_min                  frame extremes (FP_QNAN if nothing ordered)
//   out_max_idx, out_min_idx          0-based position of each extreme
//   out_count                         elements accepted, NaNs included, saturating
//   out_nan_seen, out_empty, out_sat  frame flags
//
// The output ports are the accumulator registers themselves, so the record is
// stable for as long as it is held in DONE.
module float_minmax_reduce
    import fpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_max,
    output logic [31:0]      out_min,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nan_seen,
    output logic             out_empty,
    output logic             out_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;

    logic beat;
    logic is_nan;
    logic max_ge;     // in_data >= current max
    logic min_ge;     // current min >= in_data
    logic upd_max;
    logic upd_min;

    // ------------------------------------------------------------------
    // Ordering decisions: one comparator per path, straight off the
    // registered extremes. Bitwise equality is excluded so that ties keep
    // the earlier index.
    // ------------------------------------------------------------------
    FloatingCompare u_cmp_max (
        .a  (in_data),
        .b  (out_max),
        .ge (max_ge)
    );

    FloatingCompare u_cmp_min (
        .a  (out_min),
        .b  (in_data),
        .ge (min_ge)
    );

    assign is_nan  = fp_is_nan(in_data);
    assign upd_max = max_ge && (in_data != out_max);
    assign upd_min = min_ge && (in_data != out_min);

    assign in_ready  = (state != ST_DONE);
    assign out_valid = (state == ST_DONE);
    assign beat      = in_valid && in_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (beat) begin
                    if (in_last) begin
                        state_nxt = ST_DONE;
                    end else if (!is_nan) begin
                        state_nxt = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                if (beat && in_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulators
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_max      <= 32'd0;
            out_min      <= 32'd0;
            out_max_idx  <= '0;
            out_min_idx  <= '0;
            out_count    <= '0;
            out_nan_seen <= 1'b0;
            out_empty    <= 1'b0;
            out_sat      <= 1'b0;
        end else if (state == ST_DONE) begin
            // Record consumed: start the next frame from a clean slate.
            if (out_ready) begin
                out_max      <= 32'd0;
                out_min      <= 32'd0;
                out_max_idx  <= '0;
                out_min_idx  <= '0;
                out_count    <= '0;
                out_nan_seen <= 1'b0;
                out_empty    <= 1'b0;
                out_sat      <= 1'b0;
            end
        end else if (beat) begin
            // Count first; the element's index is the pre-increment value.
            if (out_count == CNT_MAX) begin
                out_sat <= 1'b1;
            end else begin
                out_count <= out_count + CNT_ONE;
            end

            if (is_nan) begin
                out_nan_seen <= 1'b1;
                // Closing a frame that never saw an ordered element.
                if (in_last && (state == ST_IDLE)) begin
                    out_max     <= FP_QNAN;
                    out_min     <= FP_QNAN;
                    out_max_idx <= '0;
                    out_min_idx <= '0;
                    out_empty   <= 1'b1;
                end
            end else if (state == ST_IDLE) begin
                out_max     <= in_data;
                out_min     <= in_data;
                out_max_idx <= out_count;
                out_min_idx <= out_count;
            end else begin
                if (upd_max) begin
                    out_max     <= in_data;
                    out_max_idx <= out_count;
                end
                if (upd_min) begin
                    out_min     <= in_data;
                    out_min_idx <= out_count;
                end
            end
        end
    end

endmodule

// File: tb/tb_float_minmax_reduce.sv
// Randomised + directed bench for float_minmax_reduce with a queue scoreboard.
// Two instances: CNT_W=16 for normal frames, CNT_W=2 to exercise saturation.
module tb_float_minmax_reduce;

    localparam int W0 = 16;
    localparam int W1 = 2;

    typedef struct {
        logic [31:0] mx;
        logic [31:0] mn;
        int          mx_i;
        int          mn_i;
        int          cnt;
        logic        nan;
        logic        emp;
        logic        sat;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // instance 0
    logic          v0, r0, l0, ov0, or0;
    logic [31:0]   d0, mx0, mn0;
    logic [W0-1:0] mxi0, mni0, cnt0;
    logic          nan0, emp0, sat0;
    // instance 1
    logic          v1, r1, l1, ov1, or1;
    logic [31:0]   d1, mx1, mn1;
    logic [W1-1:0] mxi1, mni1, cnt1;
    logic          nan1, emp1, sat1;

    float_minmax_reduce #(.CNT_W(W0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v0), .in_ready(r0), .in_data(d0), .in_last(l0),
        .out_valid(ov0), .out_ready(or0),
        .out_max(mx0), .out_min(mn0), .out_max_idx(mxi0), .out_min_idx(mni0),
        .out_count(cnt0), .out_nan_seen(nan0), .out_empty(emp0), .out_sat(sat0)
    );

    float_minmax_reduce #(.CNT_W(W1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(r1), .in_data(d1), .in_last(l1),
        .out_valid(ov1), .out_ready(or1),
        .out_max(mx1), .out_min(mn1), .out_max_idx(mxi1), .out_min_idx(mni1),
        .out_count(cnt1), .out_nan_seen(nan1), .out_empty(emp1), .out_sat(sat1)
    );

    int checks = 0;
    int errors = 0;
    rec_t q0[$];
    rec_t q1[$];
    int bp_mode = 0;   // 0 random out_ready, 1 hold low, 2 hold high

    // ------------------------------------------------------------------
    // Reference model: total-order key on the float encoding, strictly
    // greater/less scan so the first occurrence of an extreme wins.
    // ------------------------------------------------------------------
    function automatic logic is_nan_f(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 0);
    endfunction

    function automatic logic [31:0] okey(input logic [31:0] f);
        return f[31] ? ~f : (f | 32'h8000_0000);
    endfunction

    function automatic rec_t model(input logic [31:0] w[$], input int cmax);
        rec_t r;
        bit   found = 0;
        r.mx = 32'h7FC0_0000; r.mn = 32'h7FC0_0000;
        r.mx_i = 0; r.mn_i = 0; r.nan = 0;
        for (int i = 0; i < w.size(); i++) begin
            int pos = (i > cmax) ? cmax : i;
            if (is_nan_f(w[i])) begin
                r.nan = 1;
            end else if (!found) begin
                found = 1;
                r.mx = w[i]; r.mn = w[i]; r.mx_i = pos; r.mn_i = pos;
            end else begin
                if (okey(w[i]) > okey(r.mx)) begin r.mx = w[i]; r.mx_i = pos; end
                if (okey(w[i]) < okey(r.mn)) begin r.mn = w[i]; r.mn_i = pos; end
            end
        end
        r.cnt = (w.size() > cmax) ? cmax : w.size();
        r.sat = (w.size() > cmax);
        r.emp = !found;
        return r;
    endfunction

    function automatic rec_t got0();
        rec_t r;
        r.mx = mx0; r.mn = mn0; r.mx_i = int'(mxi0); r.mn_i = int'(mni0);
        r.cnt = int'(cnt0); r.nan = nan0; r.emp = emp0; r.sat = sat0;
        return r;
    endfunction

    function automatic rec_t got1();
        rec_t r;
        r.mx = mx1; r.mn = mn1; r.mx_i = int'(mxi1); r.mn_i = int'(mni1);
        r.cnt = int'(cnt1); r.nan = nan1; r.emp = emp1; r.sat = sat1;
        return r;
    endfunction

    task automatic cmp_rec(input string name, input rec_t g, input rec_t e);
        checks++;
        if (g != e) begin
            errors++;
            $display("FAIL %s: got max=%h(%0d) min=%h(%0d) cnt=%0d nan=%b emp=%b sat=%b, expected max=%h(%0d) min=%h(%0d) cnt=%0d nan=%b emp=%b sat=%b",
                     name, g.mx, g.mx_i, g.mn, g.mn_i, g.cnt, g.nan, g.emp, g.sat,
                     e.mx, e.mx_i, e.mn, e.mn_i, e.cnt, e.nan, e.emp, e.sat);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, g, e);
        end
    endtask

    // ------------------------------------------------------------------
    // out_ready drivers
    // ------------------------------------------------------------------
    initial begin
        or0 = 1'b0;
        or1 = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                1:       or0 = 1'b0;
                2:       or0 = 1'b1;
                default: or0 = ($urandom_range(0, 3) != 0);
            endcase
            or1 = $urandom_range(0, 1) != 0;
        end
    end

    // ------------------------------------------------------------------
    // Monitors: pop on handshake; also check the held record stays put.
    // ------------------------------------------------------------------
    initial begin
        rec_t prev;
        bit   hold = 0;
        forever begin
            @(negedge clk);
            if (hold) begin
                if (ov0) cmp_rec("hold_stable0", got0(), prev);
                else chk("hold_valid0", 32'(ov0), 32'd1);
            end
            hold = 0;
            if (ov0 && or0) begin
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rec0: got a record, expected none");
                end else begin
                    cmp_rec("rec0", got0(), q0.pop_front());
                end
            end else if (ov0) begin
                hold = 1;
                prev = got0();
            end
        end
    end

    initial begin
        rec_t prev;
        bit   hold = 0;
        forever begin
            @(negedge clk);
            if (hold) begin
                if (ov1) cmp_rec("hold_stable1", got1(), prev);
                else chk("hold_valid1", 32'(ov1), 32'd1);
            end
            hold = 0;
            if (ov1 && or1) begin
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rec1: got a record, expected none");
                end else begin
                    cmp_rec("rec1", got1(), q1.pop_front());
                end
            end else if (ov1) begin
                hold = 1;
                prev = got1();
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic beat(input int u, input logic [31:0] d, input logic l);
        int t = 0;
        @(negedge clk);
        if (u == 0) begin v0 = 1'b1; d0 = d; l0 = l; end
        else        begin v1 = 1'b1; d1 = d; l1 = l; end
        while (((u == 0) ? r0 : r1) == 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 500 cycles, expected 1");
        end
        @(posedge clk); #1;
        if (u == 0) begin v0 = 1'b0; d0 = $urandom; l0 = $urandom_range(0, 1) != 0; end
        else        begin v1 = 1'b0; d1 = $urandom; l1 = $urandom_range(0, 1) != 0; end
        if (l) begin
            chk("last_latency", 32'((u == 0) ? ov0 : ov1), 32'd1);
            chk("ready_low_done", 32'((u == 0) ? r0 : r1), 32'd0);
        end
    endtask

    task automatic send_frame(input int u, input logic [31:0] w[$]);
        if (u == 0) q0.push_back(model(w, (1 << W0) - 1));
        else        q1.push_back(model(w, (1 << W1) - 1));
        for (int i = 0; i < w.size(); i++) beat(u, w[i], i == w.size() - 1);
    endtask

    function automatic logic [31:0] rnd_elem(input logic [31:0] sofar[$]);
        int sel = $urandom_range(0, 9);
        logic [31:0] v;
        case (sel)
            0, 1, 2: begin
                case ($urandom_range(0, 9))
                    0: v = 32'h0000_0000;
                    1: v = 32'h8000_0000;
                    2: v = 32'h7F80_0000;
                    3: v = 32'hFF80_0000;
                    4: v = 32'h7FC0_0000;
                    5: v = 32'h7F80_0001;
                    6: v = 32'hFFFF_FFFF;
                    7: v = 32'h0000_0001;
                    8: v = 32'h8000_0001;
                    default: v = 32'h3F80_0000;
                endcase
            end
            3, 4: v = $urandom;
            5: v = (sofar.size() > 0) ? sofar[$urandom_range(0, sofar.size() - 1)] : 32'hBF80_0000;
            default: v = {1'($urandom_range(0, 1)), 8'(8'd120 + 8'($urandom_range(0, 15))), 23'($urandom)};
        endcase
        return v;
    endfunction

    task automatic wait_drain(input string name);
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 2000) begin
            errors++;
            $display("FAIL %s: got %0d/%0d records pending, expected 0", name, q0.size(), q1.size());
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] fr[$];
        rst_n = 1'b0;
        v0 = 0; d0 = 0; l0 = 0;
        v1 = 0; d1 = 0; l1 = 0;
        #12;
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_in_ready", 32'(r0), 32'd1);
        chk("rst_max", mx0, 32'd0);
        chk("rst_min", mn0, 32'd0);
        chk("rst_cnt_flags", {16'(cnt0), 13'd0, nan0, emp0, sat0}, 32'd0);
        chk("rst_idx", {16'(mxi0), 16'(mni0)}, 32'd0);
        chk("rst_out_valid1", 32'(ov1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed frames
        fr = '{32'h3F80_0000, 32'hC020_0000, 32'h40E0_0000, 32'h3F00_0000}; send_frame(0, fr);
        fr = '{32'h3F80_0000, 32'h3F80_0000};                               send_frame(0, fr);
        fr = '{32'hC000_0000, 32'hC000_0000, 32'hC000_0000};                send_frame(0, fr);
        fr = '{32'h7FC0_0001, 32'h4000_0000, 32'hFFC0_0000};                send_frame(0, fr);
        fr = '{32'h7F80_0001};                                              send_frame(0, fr);
        fr = '{32'h8000_0000, 32'h0000_0000, 32'hFF80_0000};                send_frame(0, fr);
        fr = '{32'h0000_0000, 32'h8000_0000};                               send_frame(0, fr);
        wait_drain("drain_directed");

        // Back-pressure: hold the record 5 cycles, then release.
        bp_mode = 1;
        @(posedge clk); #2;
        fr = '{32'h4000_0000, 32'hC080_0000, 32'h7F80_0000}; send_frame(0, fr);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(r0), 32'd0);
            chk("bp_out_valid", 32'(ov0), 32'd1);
        end
        bp_mode = 2;
        @(posedge clk); #2;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", 32'(r0), 32'd1);
        fr = '{32'h4120_0000}; send_frame(0, fr);
        wait_drain("drain_bp");
        bp_mode = 0;

        // Mid-frame reset: partial frame must vanish.
        beat(0, 32'h4040_0000, 1'b0);
        beat(0, 32'hC040_0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_max", mx0, 32'd0);
        chk("mid_rst_min", mn0, 32'd0);
        chk("mid_rst_cnt", 32'(cnt0), 32'd0);
        chk("mid_rst_ready", 32'(r0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        fr = '{32'h3F00_0000, 32'hBF00_0000}; send_frame(0, fr);

        // Saturation with a 2-bit counter.
        fr = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'hC0A0_0000};
        send_frame(1, fr);
        fr = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000}; send_frame(1, fr);
        wait_drain("drain_reset_sat");

        // Randomised frames
        for (int f = 0; f < 40; f++) begin
            int n = $urandom_range(1, 12);
            fr = {};
            for (int i = 0; i < n; i++) fr.push_back(rnd_elem(fr));
            send_frame(0, fr);
        end
        for (int f = 0; f < 20; f++) begin
            int n = $urandom_range(1, 7);
            fr = {};
            for (int i = 0; i < n; i++) fr.push_back(rnd_elem(fr));
            send_frame(1, fr);
        end
        wait_drain("drain_random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500us, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/float_minmax_reduce.md
# float_minmax_reduce

Streaming reduction stage that consumes a frame of IEEE-754 single-precision values and reports the frame's maximum and minimum, their positions, and the element count. It sits downstream of the combinational `FloatingCompare` (A >= B) comparator and instantiates it for every ordering decision. Input and output use valid/ready handshakes. Output is one result record per frame, delimited by `in_last`.

## Interface
- `CNT_W`, default 16: width of element count and index fields. Count and index saturate at 2^CNT_W-1.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input element valid
- `in_ready`  out  1  block can accept an element
- `in_data`  in  32  IEEE-754 single
- `in_last`  in  1  element is the final one of the frame
- `out_valid`  out  1  result record valid
- `out_ready`  in  1  downstream accepts the record
- `out_max`, `out_min`  out  32  frame maximum and minimum
- `out_max_idx`, `out_min_idx`  out  CNT_W  0-based position of each within the frame
- `out_count`  out  CNT_W  elements accepted in the frame, including NaNs
- `out_nan_seen`  out  1  at least one NaN was in the frame
- `out_empty`  out  1  no non-NaN element was in the frame
- `out_sat`  out  1  count saturated

## Operation
- **Beat:** an element is accepted when `in_valid && in_ready`.
- **States:**
  - IDLE: no ordered element held yet. `in_ready`=1.
  - ACC: at least one ordered element held. `in_ready`=1.
  - DONE: result held. `in_ready`=0, `out_valid`=1.
- **NaN test:** exponent is 8'hFF and mantissa is nonzero. A NaN element:
  - increments the count and sets `nan_seen`;
  - never updates max or min;
  - does not change IDLE/ACC state.
- **First non-NaN element** (state IDLE): loads it as both max and min, with both indices equal to the current count. Transition IDLE→ACC.
- **Later non-NaN element `x`** (state ACC):
  - `x` replaces the max iff `FloatingCompare(x, max)`=1 and `x != max` bitwise.
  - `x` replaces the min iff `FloatingCompare(min, x)`=1 and `x != min` bitwise.
  - Ties therefore keep the earlier index.
- **Signed zero:** +0 ranks above -0, because the comparator's sign rule applies.
- **Infinities:** ordered normally.
- **Count and index:**
  - The index assigned to an element is the count value before that element is accepted.
  - The count saturates at the maximum value; `out_sat` is set once an increment is attempted while saturated.
- **Last beat:** accepting an element with `in_last`=1 (NaN or not) goes to DONE, with the update for that element included.
- **Empty frame:** if no ordered element was seen, `out_max`=`out_min`=32'h7FC00000, both indices are 0, and `out_empty`=1.
- **Result handshake:** in DONE, `out_valid && out_ready` goes to IDLE and clears all accumulators and flags.
- **No overlap:** frames never overlap; back-pressure on the output stalls the input.

## Timing
- **Reset values:**
  - State IDLE. `in_ready`=1.
  - `out_valid`=0.
  - All data, index, count and flag outputs = 0.
- **Mid-frame reset:** the partial frame is discarded entirely.
- **Output latency:** `out_valid` rises on the clock edge that accepts the last beat, i.e. it is visible the cycle after the last-beat handshake.
- **Stability:** outputs are registered and stable while `out_valid`=1 and `out_ready`=0.
- **Release:** `in_ready` returns to 1 in the cycle after the output handshake.
- **Throughput:**
  - One element per cycle within a frame.
  - Each frame costs one dead cycle (DONE) minimum.
- **Comparator path:** the comparator is combinational between registered max/min and `in_data`. There is no pipelining inside the block.
- **Input signals while `in_ready`=0:** `in_last` and `in_data` are ignored.

## Structure
- **Shared package `fpu_pkg`:**
  - `FP_QNAN` constant (32'h7FC00000)
  - `fp_is_nan` function
  - state enum (IDLE/ACC/DONE)
- **Sub-module:** two instances of the existing `FloatingCompare`, one for the max path and one for the min path. No other sub-module.
- **Register set:** state, max, min, two indices, count, three flags.

## Test plan
- **Basic frame:** 3F800000, C0200000, 40E00000, 3F000000(last) → max 40E00000 idx2, min C0200000 idx1, count 4, `out_valid` one cycle after the last handshake.
- **Ties:** 3F800000, 3F800000(last) → max and min 3F800000 with idx0; C0000000 ×3 → idx0 for both.
- **NaN handling:**
  - 7FC00001, 40000000, FFC00000(last) → max=min=40000000 idx1, count 3, `nan_seen`=1, `empty`=0.
  - A single 7F800001(last) → 7FC00000, `empty`=1, count 1.
- **Signed zero and infinity:** 80000000, 00000000, FF800000(last) → max 00000000 idx1, min FF800000 idx2.
- **Back-pressure:**
  - Hold `out_ready`=0 for 5 cycles → outputs unchanged and `in_ready`=0 throughout.
  - Assert `out_ready` → `in_ready`=1 the next cycle.
  - Following frame 41200000(last) → count 1, idx0, flags clear.
- **Reset and saturation:**
  - Drop `rst_n` after 2 beats → all outputs 0 immediately; the next frame is unaffected.
  - With `CNT_W`=2, send 5 beats → count 3, `out_sat`=1.
